axi_rd_arbiter: RTL
===================

# axi_rd_arbiter

Shares the single accelerator read-address/read-data channel between the feature-map address generator (`fm_*`) and the weight loader (`wt_*`). Each requester issues a one-cycle `arvalid` pulse with no ready; the block latches it, grants one burst at a time to the master port, and routes the returning beats and `rlast` back to the owner. It sits between the input/weight buffer address generators and the memory interface.

## Interface
- `AW`, 32, address width
- `DW`, 64, read data width
- `MAXLOG`, 8, largest accepted `arburst` code (burst = 2^arburst beats)
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `fm_araddr` / `wt_araddr`  in  AW  requester burst address
- `fm_arvalid` / `wt_arvalid`  in  1  one-cycle request pulse
- `fm_arburst` / `wt_arburst`  in  4  log2 burst length
- `fm_rvalid` / `wt_rvalid`  out  1  beat valid for that requester
- `fm_rdata` / `wt_rdata`  out  DW  beat data (broadcast of `m_rdata`)
- `fm_rlast` / `wt_rlast`  out  1  last beat of requester's burst
- `m_araddr`  out  AW  granted address
- `m_arvalid`  out  1  address valid, held until accepted
- `m_arburst`  out  4  granted burst code
- `m_arready`  in  1  address accepted
- `m_rvalid`, `m_rdata`, `m_rlast`  in  1/DW/1  read data channel (always accepted)
- `busy`  out  1  state != IDLE or any slot full
- `err`  out  3  sticky: [0] slot overflow, [1] burst length mismatch, [2] stray beat
- `err_clr`  in  1  clears `err`

## Operation
- Per requester one-entry slot {addr, burst, full}. Pulse loads slot; visible next cycle.
- Pulse while slot full and not being granted this cycle: request dropped, `err[0]` set.
- Pulse in the same cycle the slot is granted: slot reloads with new request, no error.
- `arburst` > MAXLOG: clamped to MAXLOG at latch time.
- FSM: IDLE -> ADDR when any slot full (grant selected, slot cleared, owner registered); ADDR -> DATA on `m_arvalid & m_arready`; DATA -> IDLE on `m_rvalid & m_rlast`.
- Grant: fixed priority, fm over wt (see Configuration).
- DATA: `<owner>_rvalid = m_rvalid`, `<owner>_rlast = m_rlast`; other requester's outputs 0. Data broadcast unconditionally.
- Beat counter 9 bits, reset at ADDR->DATA, +1 per beat. `m_rlast` on beat index != 2^burst-1, or final expected beat without `m_rlast`: `err[1]` set; `m_rlast` always ends the burst.
- `m_rvalid` outside DATA: ignored, no routing, `err[2]` set.
- `err_clr` has priority over same-cycle error set.
- One outstanding burst only; no interleaving.

## Timing
- Reset: state IDLE, slots empty, `m_arvalid` 0, `m_araddr` 0, `m_arburst` 0, all `*_rvalid`/`*_rlast` 0, `err` 0, `busy` 0. Reset mid-burst abandons the burst; no replay.
- `m_arvalid`/`m_araddr`/`m_arburst` registered; pulse at cycle t -> slot full t+1 -> `m_arvalid` high t+2 (min latency 2).
- `m_arvalid` stays high and address stable until `m_arready`.
- R routing combinational, zero latency.
- Back-to-back: IDLE re-entered the cycle after `m_rlast`; next `m_arvalid` one cycle later.

## Configuration
- `AXI_RD_ARB_RR_EN` defined: round-robin; last owner gets lowest priority on next grant when both slots full (1-bit pointer, reset favours fm).
- Undefined: fixed priority fm > wt; wt may starve while fm keeps requesting.

## Structure
- Package `arb_pkg`: state enum {IDLE, ADDR, DATA}, owner enum {OWN_FM, OWN_WT}, error bit indices, MAXLOG default.
- Sub-module `req_slot`: the one-entry latch with load/clear/overflow, instantiated twice.

## Test plan
- fm pulse addr 0x1000 burst 5 -> `m_arvalid` at t+2, addr 0x1000; 32 beats routed to fm only, `fm_rlast` on beat 32, `err`=0.
- Both pulse same cycle -> fm granted first, wt granted after fm `rlast`; with `AXI_RD_ARB_RR_EN`, second round with both pending grants wt first.
- Two fm pulses while fm pending and `m_arready` low -> second dropped, `err[0]`=1; `err_clr` -> 0.
- Burst 2 (4 beats) with `m_rlast` on beat 3 -> burst ends, `err[1]`=1, next grant proceeds.
- `m_rvalid` in IDLE -> no `*_rvalid`, `err[2]`=1.
- Assert `rst_n` low mid-DATA -> all outputs reset values immediately; new request after release served normally.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the accelerator read-channel arbiter.
package arb_pkg;

   localparam int unsigned BURST_W    = 4;
   localparam int unsigned BEAT_W     = 9;
   localparam int unsigned ERR_W      = 3;
   localparam int unsigned MAXLOG_DEF = 8;

   localparam int unsigned ERR_OVF   = 0;
   localparam int unsigned ERR_LEN   = 1;
   localparam int unsigned ERR_STRAY = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_FM = 1'b0,
      OWN_WT = 1'b1
   } arb_owner_e;

   // Index of the final beat of a 2^burst beat transfer.
   function automatic logic [BEAT_W-1:0] last_beat_idx(input logic [BURST_W-1:0] burst);
      return (BEAT_W'(1) << burst) - BEAT_W'(1);
   endfunction

endpackage

// File: rtl/req_slot.sv
// One-entry request latch: captures a one-cycle arvalid pulse and holds it until granted.
module req_slot
   import arb_pkg::*;
#(
   parameter int unsigned AW     = 32,
   parameter int unsigned MAXLOG = MAXLOG_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_i,
   input  logic [AW-1:0]      addr_i,
   input  logic [BURST_W-1:0] burst_i,
   input  logic               grant_i,
   output logic               full_o,
   output logic               full_nxt_c,
   output logic               ovf_c,
   output logic [AW-1:0]      addr_o,
   output logic [BURST_W-1:0] burst_o
);

   logic               full_q, full_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [BURST_W-1:0] burst_clamped;

   always_comb begin
      burst_clamped = burst_i;
      if (32'(burst_i) > MAXLOG) begin
         burst_clamped = BURST_W'(MAXLOG);
      end
   end

   // A pulse in the grant cycle reloads the slot; a pulse into a held slot is dropped.
   always_comb begin
      full_d  = full_q;
      addr_d  = addr_q;
      burst_d = burst_q;
      ovf_c   = req_i & full_q & ~grant_i;
      if (req_i && (!full_q || grant_i)) begin
         full_d  = 1'b1;
         addr_d  = addr_i;
         burst_d = burst_clamped;
      end else if (grant_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         addr_q  <= '0;
         burst_q <= '0;
      end else begin
         full_q  <= full_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
      end
   end

   assign full_o     = full_q;
   assign full_nxt_c = full_d;
   assign addr_o     = addr_q;
   assign burst_o    = burst_q;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester read-channel arbiter, one outstanding burst at a time.
// Define AXI_RD_ARB_RR_EN for round-robin grant; default is fixed priority fm > wt.
module axi_rd_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 64,
   parameter int unsigned MAXLOG = MAXLOG_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [AW-1:0]      fm_araddr,
   input  logic               fm_arvalid,
   input  logic [BURST_W-1:0] fm_arburst,
   output logic               fm_rvalid,
   output logic [DW-1:0]      fm_rdata,
   output logic               fm_rlast,
   input  logic [AW-1:0]      wt_araddr,
   input  logic               wt_arvalid,
   input  logic [BURST_W-1:0] wt_arburst,
   output logic               wt_rvalid,
   output logic [DW-1:0]      wt_rdata,
   output logic               wt_rlast,
   output logic [AW-1:0]      m_araddr,
   output logic               m_arvalid,
   output logic [BURST_W-1:0] m_arburst,
   input  logic               m_arready,
   input  logic               m_rvalid,
   input  logic [DW-1:0]      m_rdata,
   input  logic               m_rlast,
   output logic               busy,
   output logic [ERR_W-1:0]   err,
   input  logic               err_clr
);

   logic               fm_full, fm_full_nxt, fm_ovf, fm_grant;
   logic [AW-1:0]      fm_slot_addr;
   logic [BURST_W-1:0] fm_slot_burst;
   logic               wt_full, wt_full_nxt, wt_ovf, wt_grant;
   logic [AW-1:0]      wt_slot_addr;
   logic [BURST_W-1:0] wt_slot_burst;

   arb_state_e         state_q, state_d;
   arb_owner_e         owner_q, owner_d;
   logic [AW-1:0]      m_araddr_q, m_araddr_d;
   logic               m_arvalid_q, m_arvalid_d;
   logic [BURST_W-1:0] m_arburst_q, m_arburst_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [ERR_W-1:0]   err_q, err_d, err_set;
   logic               busy_q, busy_d;
   logic               pick_wt, len_err, stray;

   req_slot #(.AW(AW), .MAXLOG(MAXLOG)) u_fm_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (fm_arvalid),
      .addr_i     (fm_araddr),
      .burst_i    (fm_arburst),
      .grant_i    (fm_grant),
      .full_o     (fm_full),
      .full_nxt_c (fm_full_nxt),
      .ovf_c      (fm_ovf),
      .addr_o     (fm_slot_addr),
      .burst_o    (fm_slot_burst)
   );

   req_slot #(.AW(AW), .MAXLOG(MAXLOG)) u_wt_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (wt_arvalid),
      .addr_i     (wt_araddr),
      .burst_i    (wt_arburst),
      .grant_i    (wt_grant),
      .full_o     (wt_full),
      .full_nxt_c (wt_full_nxt),
      .ovf_c      (wt_ovf),
      .addr_o     (wt_slot_addr),
      .burst_o    (wt_slot_burst)
   );

`ifdef AXI_RD_ARB_RR_EN
   // Pointer set after an fm grant so wt wins the next contested grant.
   logic prio_wt_q, prio_wt_d;

   always_comb begin
      prio_wt_d = prio_wt_q;
      if (fm_grant) begin
         prio_wt_d = 1'b1;
      end else if (wt_grant) begin
         prio_wt_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_wt_q <= 1'b0;
      end else begin
         prio_wt_q <= prio_wt_d;
      end
   end

   assign pick_wt = wt_full & (~fm_full | prio_wt_q);
`else
   assign pick_wt = wt_full & ~fm_full;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      m_araddr_d  = m_araddr_q;
      m_arvalid_d = m_arvalid_q;
      m_arburst_d = m_arburst_q;
      beat_d      = beat_q;
      fm_grant    = 1'b0;
      wt_grant    = 1'b0;
      len_err     = 1'b0;
      case (state_q)
         IDLE: begin
            if (fm_full || wt_full) begin
               state_d     = ADDR;
               m_arvalid_d = 1'b1;
               if (pick_wt) begin
                  owner_d     = OWN_WT;
                  wt_grant    = 1'b1;
                  m_araddr_d  = wt_slot_addr;
                  m_arburst_d = wt_slot_burst;
               end else begin
                  owner_d     = OWN_FM;
                  fm_grant    = 1'b1;
                  m_araddr_d  = fm_slot_addr;
                  m_arburst_d = fm_slot_burst;
               end
            end
         end
         ADDR: begin
            if (m_arready) begin
               state_d     = DATA;
               m_arvalid_d = 1'b0;
               beat_d      = '0;
            end
         end
         DATA: begin
            if (m_rvalid) begin
               beat_d = beat_q + BEAT_W'(1);
               // rlast must coincide exactly with the final expected beat
               if (m_rlast != (beat_q == last_beat_idx(m_arburst_q))) begin
                  len_err = 1'b1;
               end
               if (m_rlast) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign stray = m_rvalid & (state_q != DATA);

   always_comb begin
      err_set            = '0;
      err_set[ERR_OVF]   = fm_ovf | wt_ovf;
      err_set[ERR_LEN]   = len_err;
      err_set[ERR_STRAY] = stray;
      err_d              = err_clr ? '0 : (err_q | err_set);
   end

   assign busy_d = (state_d != IDLE) | fm_full_nxt | wt_full_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_FM;
         m_araddr_q  <= '0;
         m_arvalid_q <= 1'b0;
         m_arburst_q <= '0;
         beat_q      <= '0;
         err_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         m_araddr_q  <= m_araddr_d;
         m_arvalid_q <= m_arvalid_d;
         m_arburst_q <= m_arburst_d;
         beat_q      <= beat_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   // Read-data routing is combinational so beats reach the owner with no added latency.
   assign fm_rvalid = m_rvalid & (state_q == DATA) & (owner_q == OWN_FM);
   assign fm_rlast  = m_rlast  & (state_q == DATA) & (owner_q == OWN_FM) & m_rvalid;
   assign wt_rvalid = m_rvalid & (state_q == DATA) & (owner_q == OWN_WT);
   assign wt_rlast  = m_rlast  & (state_q == DATA) & (owner_q == OWN_WT) & m_rvalid;
   assign fm_rdata  = m_rdata;
   assign wt_rdata  = m_rdata;

   assign m_araddr  = m_araddr_q;
   assign m_arvalid = m_arvalid_q;
   assign m_arburst = m_arburst_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule
